hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU sequencer. It fetches 16-bit Hack instructions, decodes C-instructions into the six ALU control bits, feeds the ALU its x/y operands, and consumes the ALU's out/zr/ng.
- It owns the A, D and PC registers and drives req/ack handshakes to instruction ROM and data RAM.
- It sits between memory and the combinational ALU and is the producer side of the ALU control interface.

Parameters:
- WIDTH, 16, data and instruction word width (fixed at 16 for Hack encoding; other values unsupported).
- ADDR_W, 15, ROM/RAM address width; addresses are A[ADDR_W-1:0] and PC[ADDR_W-1:0].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rom_req  out  1  instruction fetch request.
- rom_addr  out  ADDR_W  fetch address (= PC).
- rom_ack  in  1  fetch done; rom_data valid this cycle.
- rom_data  in  WIDTH  instruction word.
- mem_req  out  1  data memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  data address.
- mem_wdata  out  WIDTH  write data.
- mem_ack  in  1  access done; mem_rdata valid on reads.
- mem_rdata  in  WIDTH  read data.
- alu_x  out  WIDTH  ALU x operand (= D).
- alu_y  out  WIDTH  ALU y operand (A, or latched M when a-bit = 1).
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU controls = IR[11:6] in that order.
- alu_out  in  WIDTH  ALU result.
- alu_zr  in  1  ALU result is zero.
- alu_ng  in  1  ALU result is negative.
- pc  out  ADDR_W  current PC (debug).
- halted_fetch  out  1  high in FETCH while waiting for rom_ack (debug/perf).

Behaviour:
- Reset (synchronous): PC = 0, A = 0, D = 0, IR = 0, Mreg = 0, state = FETCH. rom_req and mem_req are low in the cycle after reset is sampled. Reset overrides every state, including an outstanding handshake; a late ack after reset is ignored.
- Handshake: req is registered and held with stable addr/we/wdata until ack is sampled high. Transfer completes on the clock edge where req && ack. req drops the next cycle. ack while req is low is ignored.
- States and transitions:
  - FETCH: rom_req = 1, rom_addr = PC. On rom_ack: IR <= rom_data, go to DECODE.
  - DECODE, IR[15] = 0 (A-instr): A <= IR, PC <= PC+1, go to FETCH.
  - DECODE, IR[15] = 1, IR[12] = 1: go to RDM.
  - DECODE, IR[15] = 1, IR[12] = 0: go to EXEC.
  - RDM: mem_req = 1, mem_we = 0, mem_addr = A. On mem_ack: Mreg <= mem_rdata, go to EXEC.
  - EXEC:
    - alu_y = IR[12] ? Mreg : A.
    - Capture res = alu_out, a_old = A.
    - If IR[5]: A <= res. If IR[4]: D <= res.
    - jmp = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr).
    - If IR[3]: latch wr_addr = a_old, wr_data = res, pc_next = jmp ? a_old : PC+1; go to WRM.
    - Otherwise: PC <= jmp ? a_old : PC+1; go to FETCH.
  - WRM: mem_req = 1, mem_we = 1, mem_addr = wr_addr, mem_wdata = wr_data. On mem_ack: PC <= pc_next, go to FETCH.
- Jump target and M address always use A before this instruction's dest write. Example: AM=M+1 writes to the old A address.
- ALU controls are driven combinationally from IR in every state; they are only consumed in EXEC. alu_x = D at all times.
- PC increment wraps modulo 2^ADDR_W (0x7FFF+1 -> 0).
- Latency with zero-wait memory:
  - A-instr: 2 cycles.
  - C-instr without M: 3 cycles.
  - +1 cycle for an M read.
  - +1 cycle for an M write.
  - Each ack wait cycle adds 1.
- Bits IR[14:13] are ignored.

Decomposition:
- Package hack_pkg: state enum (FETCH, DECODE, RDM, EXEC, WRM); instruction field bit-position constants (CI = 15, ABIT = 12, CTRL_HI = 11, CTRL_LO = 6, DA = 5, DD = 4, DM = 3, J_LT = 2, J_EQ = 1, J_GT = 0); WIDTH/ADDR_W defaults.
- One sub-module, hack_jump_cond: combinational jmp from j[2:0], zr, ng.

Test Plan:
- Reset, then ROM {0x0005}, zero-wait -> after 2 cycles A = 5, PC = 1; exactly one rom_req with addr 0.
- @5 then 0xEC10 (D=A) -> ALU controls = 110000 in EXEC, D = 5, PC = 2, no mem_req.
- @100, 0xE308 (M=D) with D = 5, mem_ack delayed 3 cycles -> mem_req held 4 cycles, addr 100, wdata 5, we = 1; PC advances only on ack.
- @20, 0xE301 (D;JGT): D = 5 -> PC = 20; D = 0 -> PC = old+1; D = 0xFFFF -> PC = old+1.
- @7, 0xFDD0 (D=M+1) with RAM[7] = 41 -> RDM read addr 7, alu_y = 41, D = 42; AM=M+1 (0xFDE8) writes addr 7 (old A), A = 42.
- Reset asserted during WRM with ack withheld -> mem_req low next cycle, PC = 0, A = D = 0; an ack arriving afterwards causes no write-back or state change.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: word sizes, instruction
// field positions, sequencer state codes and the ALU control bundle.
package hack_pkg;

    localparam int HACK_WIDTH  = 16;
    localparam int HACK_ADDR_W = 15;

    // Bit positions inside a 16-bit Hack instruction word.
    localparam int CI      = 15;
    localparam int ABIT    = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DA      = 5;
    localparam int DD      = 4;
    localparam int DM      = 3;
    localparam int J_LT    = 2;
    localparam int J_EQ    = 1;
    localparam int J_GT    = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_RDM    = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WRM    = 3'd4;

    // Field order matches IR[11:6] so a plain cast maps the slice.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump predicate of a Hack C-instruction: selects which of the ALU result
// sign classes (<0, =0, >0) cause a branch.
module hack_jump_cond
    import hack_pkg::*;
(
    input  logic [2:0] i_j,
    input  logic       i_zr,
    input  logic       i_ng,
    output logic       o_jmp
);

    logic w_lt;
    logic w_eq;
    logic w_gt;

    assign w_lt  = i_j[J_LT] & i_ng;
    assign w_eq  = i_j[J_EQ] & i_zr;
    assign w_gt  = i_j[J_GT] & ~i_ng & ~i_zr;
    assign o_jmp = w_lt | w_eq | w_gt;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetches from ROM, decodes C-instructions
// into ALU controls, owns A/D/PC and performs M reads/writes via req/ack.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int WIDTH  = HACK_WIDTH,
    parameter int ADDR_W = HACK_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [ADDR_W-1:0] pc,
    output logic              halted_fetch
);

    // Handshake: a req is registered, and it and its addr/we/wdata stay
    // stable until the clock edge on which req && ack are both high; that
    // edge completes the transfer and req is low the following cycle. An ack
    // seen while req is low does nothing.

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_d;
    logic [WIDTH-1:0]  r_ir;
    logic [WIDTH-1:0]  r_mreg;
    logic              r_rom_req;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WIDTH-1:0]  r_mem_wdata;

    logic              w_jmp;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_a_addr;
    logic [ADDR_W-1:0] w_exec_pc;
    logic              w_rom_done;
    logic              w_mem_done;
    alu_ctrl_t         w_ctrl;

    hack_jump_cond u_jump (
        .i_j   (r_ir[J_LT:J_GT]),
        .i_zr  (alu_zr),
        .i_ng  (alu_ng),
        .o_jmp (w_jmp)
    );

    // A is sampled before this instruction's own dest write, so the jump
    // target and the M address both see the pre-execution A.
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_a_addr   = r_a[ADDR_W-1:0];
    assign w_exec_pc  = w_jmp ? w_a_addr : w_pc_inc;
    assign w_rom_done = r_rom_req && rom_ack;
    assign w_mem_done = r_mem_req && mem_ack;
    assign w_ctrl     = alu_ctrl_t'(r_ir[CTRL_HI:CTRL_LO]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= '0;
            r_pc_next   <= '0;
            r_a         <= '0;
            r_d         <= '0;
            r_ir        <= '0;
            r_mreg      <= '0;
            r_rom_req   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_rom_done) begin
                        r_ir      <= rom_data;
                        r_rom_req <= 1'b0;
                        r_state   <= ST_DECODE;
                    end else begin
                        r_rom_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (!r_ir[CI]) begin
                        r_a       <= r_ir;
                        r_pc      <= w_pc_inc;
                        r_rom_req <= 1'b1;
                        r_state   <= ST_FETCH;
                    end else if (r_ir[ABIT]) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_a_addr;
                        r_state    <= ST_RDM;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_RDM: begin
                    if (w_mem_done) begin
                        r_mreg    <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_ir[DA]) begin
                        r_a <= alu_out;
                    end
                    if (r_ir[DD]) begin
                        r_d <= alu_out;
                    end
                    if (r_ir[DM]) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_a_addr;
                        r_mem_wdata <= alu_out;
                        r_pc_next   <= w_exec_pc;
                        r_state     <= ST_WRM;
                    end else begin
                        r_pc      <= w_exec_pc;
                        r_rom_req <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_WRM: begin
                    if (w_mem_done) begin
                        r_pc      <= r_pc_next;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_rom_req <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                default: begin
                    r_rom_req <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= ST_FETCH;
                end
            endcase
        end
    end

    assign rom_req      = r_rom_req;
    assign rom_addr     = r_pc;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign alu_x        = r_d;
    assign alu_y        = r_ir[ABIT] ? r_mreg : r_a;
    assign alu_zx       = w_ctrl.zx;
    assign alu_nx       = w_ctrl.nx;
    assign alu_zy       = w_ctrl.zy;
    assign alu_ny       = w_ctrl.ny;
    assign alu_f        = w_ctrl.f;
    assign alu_no       = w_ctrl.no;
    assign pc           = r_pc;
    assign halted_fetch = (r_state == ST_FETCH) && !w_rom_done;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: behavioural ROM/RAM responders, a Hack ALU model,
// a scoreboard of expected bus/fetch events, and directed register checks.
module tb_hack_cpu_ctrl;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack = 1'b0;
    logic [WIDTH-1:0]  rom_data = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack = 1'b0;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic [WIDTH-1:0]  alu_x;
    logic [WIDTH-1:0]  alu_y;
    logic              alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic [ADDR_W-1:0] pc;
    logic              halted_fetch;

    hack_cpu_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_zx       (alu_zx),
        .alu_nx       (alu_nx),
        .alu_zy       (alu_zy),
        .alu_ny       (alu_ny),
        .alu_f        (alu_f),
        .alu_no       (alu_no),
        .alu_out      (alu_out),
        .alu_zr       (alu_zr),
        .alu_ng       (alu_ng),
        .pc           (pc),
        .halted_fetch (halted_fetch)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- Hack ALU model ----------------
    logic [WIDTH-1:0] m_x1, m_x2, m_y1, m_y2, m_f;
    always_comb begin
        m_x1    = alu_zx ? '0 : alu_x;
        m_x2    = alu_nx ? ~m_x1 : m_x1;
        m_y1    = alu_zy ? '0 : alu_y;
        m_y2    = alu_ny ? ~m_y1 : m_y1;
        m_f     = alu_f ? (m_x2 + m_y2) : (m_x2 & m_y2);
        alu_out = alu_no ? ~m_f : m_f;
        alu_zr  = (alu_out == '0);
        alu_ng  = alu_out[WIDTH-1];
    end

    // ---------------- memories and responders ----------------
    logic [WIDTH-1:0] rom [0:32767];
    logic [WIDTH-1:0] ram [0:32767];
    int fetch_cnt    = 0;
    int fetch_budget = 0;
    int mem_cnt      = 0;
    bit mem_block    = 1'b0;
    bit mem_force    = 1'b0;

    always @(negedge clk) begin
        if (reset || !rom_req) begin
            rom_ack = 1'b0;
        end else begin
            rom_ack = (fetch_cnt < fetch_budget);
            if (rom_ack) begin
                rom_data = rom[rom_addr];
                fetch_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_cnt = 0;
            mem_ack = mem_force;
        end else begin
            mem_ack = !mem_block && (mem_cnt >= ((mem_addr == 15'd100) ? 3 : 0));
            mem_cnt++;
            if (mem_ack) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata = ram[mem_addr];
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Record: {kind, addr, d0, d1, c}
    //   fetch (kind 0): addr=rom_addr, d0=alu_x, d1=alu_y, c=ALU controls
    //   read/write (1/2): addr=mem_addr, d0=wdata (0 on read), d1=pc, c=req cycles
    logic [54:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int mem_hold = 0;

    function automatic logic [54:0] rec(input logic [1:0] k, input logic [14:0] a,
                                        input logic [15:0] d0, input logic [15:0] d1,
                                        input logic [5:0] c);
        return {k, a, d0, d1, c};
    endfunction

    task automatic exp_f(input logic [14:0] a, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c);
        exp_q.push_back(rec(2'd0, a, x, y, c));
    endtask

    task automatic exp_rd(input logic [14:0] a, input logic [14:0] p, input logic [5:0] hold);
        exp_q.push_back(rec(2'd1, a, 16'h0000, {1'b0, p}, hold));
    endtask

    task automatic exp_wr(input logic [14:0] a, input logic [15:0] d, input logic [14:0] p,
                          input logic [5:0] hold);
        exp_q.push_back(rec(2'd2, a, d, {1'b0, p}, hold));
    endtask

    task automatic check_rec(input string nm, input logic [54:0] got);
        logic [54:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected event got=%h", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL %s got=%h exp=%h", nm, got, e);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] e);
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, e);
        end
    endtask

    // Monitor: samples completed transfers just after the responders settle.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            mem_hold = 0;
        end else begin
            if (mem_req) mem_hold++;
            else         mem_hold = 0;
            if (rom_req && rom_ack)
                check_rec("fetch", rec(2'd0, rom_addr, alu_x, alu_y,
                                       {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}));
            if (mem_req && mem_ack)
                check_rec(mem_we ? "mem_wr" : "mem_rd",
                          rec(mem_we ? 2'd2 : 2'd1, mem_addr, mem_we ? mem_wdata : 16'h0000,
                              {1'b0, pc}, 6'(mem_hold)));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        rom[0]  = 16'h0005;  // @5
        rom[1]  = 16'hEC10;  // D=A
        rom[2]  = 16'h0064;  // @100
        rom[3]  = 16'hE308;  // M=D   (write acked after 3 wait cycles)
        rom[4]  = 16'h0014;  // @20
        rom[5]  = 16'hE301;  // D;JGT (taken, D=5)
        rom[20] = 16'h0000;  // @0
        rom[21] = 16'hEC10;  // D=A
        rom[22] = 16'h001E;  // @30
        rom[23] = 16'hE301;  // D;JGT (not taken, D=0)
        rom[24] = 16'hEE90;  // D=-1
        rom[25] = 16'h001E;  // @30
        rom[26] = 16'hE301;  // D;JGT (not taken, D<0)
        rom[27] = 16'h0007;  // @7
        rom[28] = 16'hFDD0;  // D=M+1
        rom[29] = 16'hFDE8;  // AM=M+1
        rom[30] = 16'hEC10;  // D=A
        rom[31] = 16'h0000;  // @0
        ram[7]  = 16'd41;
        fetch_budget = 18;

        exp_f(15'd0,  16'd0,   16'd0,   6'h00);
        exp_f(15'd1,  16'd0,   16'd5,   6'h00);
        exp_f(15'd2,  16'd5,   16'd5,   6'h30);
        exp_f(15'd3,  16'd5,   16'd100, 6'h01);
        exp_wr(15'd100, 16'd5, 15'd3, 6'd4);
        exp_f(15'd4,  16'd5,   16'd100, 6'h0C);
        exp_f(15'd5,  16'd5,   16'd20,  6'h00);
        exp_f(15'd20, 16'd5,   16'd20,  6'h0C);
        exp_f(15'd21, 16'd5,   16'd0,   6'h00);
        exp_f(15'd22, 16'd0,   16'd0,   6'h30);
        exp_f(15'd23, 16'd0,   16'd30,  6'h00);
        exp_f(15'd24, 16'd0,   16'd30,  6'h0C);
        exp_f(15'd25, 16'hFFFF, 16'd30, 6'h3A);
        exp_f(15'd26, 16'hFFFF, 16'd30, 6'h00);
        exp_f(15'd27, 16'hFFFF, 16'd30, 6'h0C);
        exp_f(15'd28, 16'hFFFF, 16'd7,  6'h00);
        exp_rd(15'd7, 15'd28, 6'd1);
        exp_f(15'd29, 16'd42,  16'd41,  6'h37);
        exp_rd(15'd7, 15'd29, 6'd1);
        exp_wr(15'd7, 16'd42, 15'd29, 6'd1);
        exp_f(15'd30, 16'd42,  16'd41,  6'h37);
        exp_f(15'd31, 16'd42,  16'd42,  6'h30);

        tick();
        chk("rst_rom_req", {15'b0, rom_req}, 16'd0);
        chk("rst_mem_req", {15'b0, mem_req}, 16'd0);
        chk("rst_pc", {1'b0, pc}, 16'd0);
        chk("rst_d", alu_x, 16'd0);
        chk("rst_a", alu_y, 16'd0);
        reset = 1'b0;

        wait_drain(400);
        repeat (5) tick();
        chk("seg1_halted", {15'b0, halted_fetch}, 16'd1);
        chk("seg1_pc", {1'b0, pc}, 16'd32);
        chk("seg1_d", alu_x, 16'd42);
        chk("seg1_a", alu_y, 16'd0);
        chk("ram100", ram[100], 16'd5);
        chk("ram7", ram[7], 16'd42);

        // Reset in the middle of a withheld write.
        rom[0]   = 16'h0064;  // @100
        rom[1]   = 16'hEC10;  // D=A
        rom[2]   = 16'hE308;  // M=D
        ram[100] = 16'hBEEF;
        mem_block    = 1'b1;
        fetch_budget = 0;
        fetch_cnt    = 0;
        exp_f(15'd0, 16'd0,   16'd0,   6'h00);
        exp_f(15'd1, 16'd0,   16'd100, 6'h01);
        exp_f(15'd2, 16'd100, 16'd100, 6'h30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_budget = 3;

        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_req && mem_we) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("wrm_reached", {15'b0, seen}, 16'd1);
        chk("wrm_addr", {1'b0, mem_addr}, 16'd100);
        chk("wrm_wdata", mem_wdata, 16'd100);
        repeat (2) tick();
        chk("wrm_held", {15'b0, mem_req}, 16'd1);
        chk("wrm_pc_hold", {1'b0, pc}, 16'd2);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_mem_req", {15'b0, mem_req}, 16'd0);
        chk("rst2_pc", {1'b0, pc}, 16'd0);
        chk("rst2_d", alu_x, 16'd0);
        chk("rst2_a", alu_y, 16'd0);

        mem_block = 1'b0;
        mem_force = 1'b1;
        repeat (5) tick();
        chk("late_ack_pc", {1'b0, pc}, 16'd0);
        chk("late_ack_mem_req", {15'b0, mem_req}, 16'd0);
        chk("late_ack_ram", ram[100], 16'hBEEF);
        chk("late_ack_d", alu_x, 16'd0);
        chk("late_ack_rom_req", {15'b0, rom_req}, 16'd1);
        chk("late_ack_halted", {15'b0, halted_fetch}, 16'd1);
        mem_force = 1'b0;

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
